// File: rtl/rv32ima_pkg.sv
// Shared types for the CPU <-> RAM handshake: responder state, access width, default latency.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32ima_pkg;

    typedef enum logic [1:0] {
        RAM_FREE = 2'd0,
        RAM_ADDR = 2'd1,
        RAM_BUSY = 2'd2,
        RAM_DATA = 2'd3
    } ram_state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_width_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } ram_op_t;

    localparam int RAM_LAT_DEFAULT = 2;

endpackage

// File: rtl/ram_array.sv
// Single-port word array with per-byte write enables and a registered read port.
// Latency: read data appears the cycle after rd_en_i; writes land on the clock edge.
// Backpressure: none, always accepts.
module ram_array #(
    parameter int IDX_W     = 14,
    parameter     INIT_FILE = ""
) (
    input  logic             CLK,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             rd_en_i,
    input  logic             wr_en_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [0:(1<<IDX_W)-1];
    logic [31:0] rdata_q;

    // Byte-masked write and registered read; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// RAM end of the CPU memory handshake: latches one read/write, waits LATENCY cycles, then serves it.
// Latency: request sampled in FREE -> ADDR -> LATENCY x BUSY -> one DATA cycle -> FREE.
// Backpressure: one request in flight; requests are only accepted while ram_state is FREE.
module ram_responder
    import rv32ima_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int LATENCY   = RAM_LAT_DEFAULT,
    parameter     INIT_FILE = ""
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_store,
    input  logic        ram_ren,
    input  logic        ram_wen,
    input  logic [1:0]  ram_width,
    output logic [31:0] ram_load,
    output ram_state_t  ram_state
);

    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    ram_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       store_q, store_d;
    mem_width_t        width_q, width_d;
    ram_op_t           op_q, op_d;

    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [31:0]       rshift;
    logic              rd_en;
    logic              wr_en;

    // Address bits above the decoded range alias onto the array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ram_addr[31:ADDR_W];

    // Request FSM: next state and request latch; the latched copy is used after FREE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        store_d = store_q;
        width_d = width_q;
        op_d    = op_q;
        case (state_q)
            RAM_FREE: begin
                if (ram_ren || ram_wen) begin
                    addr_d  = ram_addr[ADDR_W-1:0];
                    store_d = ram_store;
                    width_d = (ram_width == 2'b11) ? WORD : mem_width_t'(ram_width);
                    op_d    = ram_wen ? OP_WR : OP_RD;
                    state_d = RAM_ADDR;
                end
            end
            RAM_ADDR: begin
                cnt_d   = CNT_W'(LATENCY);
                state_d = (LATENCY == 0) ? RAM_DATA : RAM_BUSY;
            end
            RAM_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RAM_DATA;
                end
            end
            default: state_d = RAM_FREE;
        endcase
    end

    // State, counter and request latch registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RAM_FREE;
            cnt_q   <= '0;
            addr_q  <= '0;
            store_q <= '0;
            width_q <= BYTE;
            op_q    <= OP_RD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            width_q <= width_d;
            op_q    <= op_d;
        end
    end

    // Byte enables and lane-replicated store data for the latched width/offset.
    always_comb begin
        be    = 4'b1111;
        wdata = store_q;
        case (width_q)
            BYTE: begin
                be    = 4'b0001 << addr_q[1:0];
                wdata = {4{store_q[7:0]}};
            end
            HALF: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Read issued on entry to DATA so the registered array output is ready there;
    // write commits on the DATA->FREE edge, so a following read sees it.
    assign rd_en = (state_d == RAM_DATA) && (op_q == OP_RD);
    assign wr_en = (state_q == RAM_DATA) && (op_q == OP_WR);

    ram_array #(
        .IDX_W     (ADDR_W - 2),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .CLK     (CLK),
        .idx_i   (addr_q[ADDR_W-1:2]),
        .rd_en_i (rd_en),
        .wr_en_i (wr_en),
        .be_i    (be),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    assign rshift = rdata >> {addr_q[1:0], 3'b000};

    // Lane select and zero extension; load is forced to zero outside DATA of a read.
    always_comb begin
        ram_load = '0;
        if (state_q == RAM_DATA && op_q == OP_RD) begin
            case (width_q)
                BYTE:    ram_load = {24'b0, rshift[7:0]};
                HALF:    ram_load = {16'b0, (addr_q[1] ? rdata[31:16] : rdata[15:0])};
                default: ram_load = rdata;
            endcase
        end
    end

    assign ram_state = state_q;

endmodule
